// File: rtl/mult_share_arbiter_if.sv
// Requester/response bundle for the shared 32-bit multiplier.
// The arbiter side uses the slave modport.
`timescale 1ns/1ps
interface mult_share_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic [ID_W-1:0]          resp_id;
  logic [31:0]              resp_data;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    input  req_ready,
    input  resp_valid,
    input  resp_id,
    input  resp_data
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    output req_ready,
    output resp_valid,
    output resp_id,
    output resp_data
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one 32-bit multiplier among NUM_REQ requesters.
// Two-stage pipe: operand regs, then product regs; tagged in-order results.
`timescale 1ns/1ps
module mult_share_mul (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_p
);
  assign o_p = i_a * i_b;
endmodule

module mult_share_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                en,
  mult_share_arbiter_if.slave bus,
  output logic                busy,
  output logic [31:0]         op_count
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST = ID_W'(NUM_REQ-1);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [NUM_REQ-1:0] w_gnt_oh;
  logic [ID_W-1:0]    w_gnt_id;
  logic               w_hs;
  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_idx;
  logic [ID_W-1:0]    w_ptr_nxt;

  logic               r_s1_v;
  logic [31:0]        r_s1_a;
  logic [31:0]        r_s1_b;
  logic [ID_W-1:0]    r_s1_id;
  logic               r_s2_v;
  logic [ID_W-1:0]    r_s2_id;
  logic [31:0]        r_s2_data;
  logic [31:0]        r_op_count;
  logic [31:0]        w_prod;

  // Grants are masked during reset so nothing leaks out before release.
  always_comb begin
    w_gnt_oh = '0;
    w_gnt_id = '0;
    w_hs     = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    if (en && reset_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
        if (w_sum >= NR) w_sum = w_sum - NR;
        w_idx = w_sum[ID_W-1:0];
        if (!w_hs && bus.req_valid[w_idx]) begin
          w_hs            = 1'b1;
          w_gnt_oh[w_idx] = 1'b1;
          w_gnt_id        = w_idx;
        end
      end
    end
  end

  assign w_ptr_nxt = (w_gnt_id == LAST) ? '0
                   : w_gnt_id + ID_W'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_v  <= 1'b0;
      r_s1_a  <= '0;
      r_s1_b  <= '0;
      r_s1_id <= '0;
    end else begin
      r_s1_v <= w_hs;
      if (w_hs) begin
        r_s1_a  <= bus.req_a[w_gnt_id];
        r_s1_b  <= bus.req_b[w_gnt_id];
        r_s1_id <= w_gnt_id;
      end
    end
  end

  mult_share_mul u_mul (
    .i_a (r_s1_a),
    .i_b (r_s1_b),
    .o_p (w_prod)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_v    <= 1'b0;
      r_s2_id   <= '0;
      r_s2_data <= '0;
    end else begin
      r_s2_v    <= r_s1_v;
      r_s2_id   <= r_s1_id;
      r_s2_data <= w_prod;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_op_count <= '0;
    end else if (r_s2_v) begin
      r_op_count <= r_op_count + 32'd1;
    end
  end

  assign bus.req_ready  = w_gnt_oh;
  assign bus.resp_valid = r_s2_v;
  assign bus.resp_id    = r_s2_id;
  assign bus.resp_data  = r_s2_data;
  assign busy           = r_s1_v | r_s2_v;
  assign op_count       = r_op_count;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Scoreboard bench for mult_share_arbiter: a reference round-robin
// model predicts grants; expected results are queued with due cycles.
`timescale 1ns/1ps
module tb_mult_share_arbiter;
  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        en;
  logic        busy;
  logic [31:0] op_count;

  mult_share_arbiter_if #(.NUM_REQ(N)) bus ();

  mult_share_arbiter #(.NUM_REQ(N)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .en       (en),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [1:0]  m_rr    = '0;
  logic [31:0] m_ops   = '0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: check at negedge, then advance past posedge.
  task automatic tick();
    logic [3:0]  eg;
    logic        hs;
    logic [1:0]  g;
    logic [31:0] p;
    int          idx;
    exp_t        e;
    @(negedge clock);
    eg = '0;
    hs = 1'b0;
    g  = '0;
    if (en && reset_n) begin
      for (int k = 0; k < N; k++) begin
        idx = (int'(m_rr) + k) % N;
        if (!hs && bus.req_valid[idx]) begin
          hs      = 1'b1;
          g       = 2'(idx);
          eg[idx] = 1'b1;
        end
      end
    end
    chk("req_ready", 32'(bus.req_ready), 32'(eg));
    chk("busy", 32'(busy), (q.size() > 0) ? 1 : 0);
    chk("op_count", op_count, m_ops);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("resp_valid", 32'(bus.resp_valid), 1);
      chk("resp_id", 32'(bus.resp_id), 32'(e.id));
      chk("resp_data", bus.resp_data, e.data);
      m_ops++;
    end else begin
      chk("resp_idle", 32'(bus.resp_valid), 0);
    end
    if (hs) begin
      p = bus.req_a[g] * bus.req_b[g];
      q.push_back('{g, p, cyc + 2});
      m_rr = g + 2'd1;
    end
    @(posedge clock);
    cyc++;
    #1;
    if (hs) begin
      bus.req_a[g] = $urandom;
      bus.req_b[g] = $urandom;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    en            = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i] = $urandom;
      bus.req_b[i] = $urandom;
    end
    ticks(2);
    reset_n = 1'b1;
    tick();
    bus.req_valid = '0;
    ticks(3);

    bus.req_a[0]  = 32'd3;
    bus.req_b[0]  = 32'd5;
    bus.req_valid = 4'b0001;
    tick();
    bus.req_valid = '0;
    ticks(3);

    bus.req_valid = '1;
    ticks(8);
    bus.req_valid = '0;
    ticks(3);

    bus.req_a[2]  = 32'h0001_0000;
    bus.req_b[2]  = 32'h0001_0000;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_a[2]  = 32'hFFFF_FFFF;
    bus.req_b[2]  = 32'd2;
    tick();
    bus.req_valid = '0;
    ticks(3);

    bus.req_valid = 4'b1011;
    ticks(5);
    en = 1'b0;
    ticks(3);
    en = 1'b1;
    ticks(4);
    bus.req_valid = '0;
    ticks(3);

    bus.req_valid = '1;
    ticks(4);
    chk("pre_rst_resp", 32'(bus.resp_valid), 1);
    chk("pre_rst_busy", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_ready", 32'(bus.req_ready), 0);
    q.delete();
    m_rr  = '0;
    m_ops = '0;
    ticks(2);
    bus.req_valid = '0;
    reset_n       = 1'b1;
    ticks(3);
    bus.req_valid = 4'b0010;
    tick();
    bus.req_valid = '0;
    ticks(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
